reload_timer_ctrl: RTL and testbench
====================================

# reload_timer_ctrl

Control stage directly upstream of the down-counter with load. It drives the counter's `action_i`/`d_i` and consumes its value and `will_underflow_o` to form a start/stop timer with one-shot and periodic auto-reload modes. It produces a single-cycle expiry tick, a sticky interrupt flag and an overrun flag for the interrupt/status logic.

## Interface
- `WORD_WIDTH`, default 8: width of the period and of the attached counter.
- `clk_i`  in  1: clock, shared with the attached counter.
- `arst_ni`  in  1: asynchronous reset, active-low. The attached counter's active-high `arst_i` is driven with `~arst_ni`.
- `start_i`  in  1: (re)start the timer; loads `period_i`.
- `stop_i`  in  1: pause the timer and freeze the counter value.
- `mode_i`  in  1: sampled with `start_i`. 0 = one-shot, 1 = periodic.
- `period_i`  in  WORD_WIDTH: reload value, sampled with `start_i`.
- `irq_clr_i`  in  1: clears `irq_o` and `overrun_o`.
- `cnt_action_o`  out  1: drives the counter's action input (1 = load, 0 = count down).
- `cnt_d_o`  out  WORD_WIDTH: drives the counter's load data.
- `cnt_q_i`  in  WORD_WIDTH: counter value.
- `cnt_zero_i`  in  1: counter's will-underflow output, equal to `cnt_q_i == 0`.
- `busy_o`  out  1: high in RUN.
- `tick_o`  out  1: one-cycle pulse, registered, in the cycle after an expiry.
- `irq_o`  out  1: sticky expiry flag.
- `overrun_o`  out  1: sticky flag for an expiry that occurs while `irq_o` is already set.

## Operation
- **Hold mechanism.** The counter always counts unless loading. To hold its value, this block drives `cnt_action_o`=1 with `cnt_d_o`=`cnt_q_i`. `cnt_d_o` is combinational from `cnt_q_i`.
- **State register.** Two states, IDLE and RUN. Registers `period_q` and `mode_q` are latched on an accepted start.
- **IDLE**
  - Hold the counter.
  - On `start_i` (and not `stop_i`): `cnt_action_o`=1, `cnt_d_o`=`period_i`, latch `period_q`/`mode_q`, go to RUN.
- **RUN, no event:** `cnt_action_o`=0, so the counter decrements.
- **Expiry** is defined as RUN and `cnt_zero_i`=1. In the expiry cycle:
  - Periodic: load `period_q`, stay in RUN.
  - One-shot: hold (counter stays 0), go to IDLE.
  - Always: `tick_o`=1 next cycle; set `irq_o`. If `irq_o` was already 1, set `overrun_o`.
- **Period.** For a period value P, consecutive expiries are P+1 cycles apart. P=0 in periodic mode expires every RUN cycle.
- **`stop_i` in RUN:** hold the counter, go to IDLE. A later `start_i` reloads; there is no resume.
- **`start_i` in RUN:** restart. Load `period_i`, re-latch `period_q`/`mode_q`, stay in RUN.
- **Priority**, highest first: `stop_i` > `start_i` > expiry reload/transition.
  - An expiry coincident with `stop_i` or `start_i` is still reported (`tick_o`, `irq_o`, `overrun_o`).
  - The counter action follows the winning command.
- **`irq_o`/`overrun_o`.** Set has priority over `irq_clr_i` in the same cycle. `overrun_o` is set only if `irq_o` was 1 and `irq_clr_i` is 0 in the expiry cycle.
- **Counter width.** Values wrap per the counter's own arithmetic. This block performs no arithmetic on the counter value.

## Timing
- **Reset (`arst_ni`=0, asynchronous):**
  - State is IDLE; `period_q`=0, `mode_q`=0.
  - `tick_o`=0, `irq_o`=0, `overrun_o`=0, `busy_o`=0.
  - `cnt_action_o`=1 and `cnt_d_o`=`cnt_q_i` (the counter is itself reset to 0).
- **Reset deassertion** is synchronised externally. The first active edge after release obeys the rules above.
- **Reset during RUN** aborts immediately. No tick is produced.
- **Start latency:** `start_i` at edge n gives counter=`period_i` and `busy_o`=1 after edge n+1.
- **Expiry latency:** with the counter at 0 during cycle k, `tick_o`/`irq_o` are high after edge k+1.
  - Periodic: the counter equals `period_q` after edge k+1.
  - One-shot: `busy_o`=0 after edge k+1.
- **Output timing:** `busy_o`, `tick_o`, `irq_o` and `overrun_o` are registered. `cnt_action_o`/`cnt_d_o` are combinational from state, inputs and `cnt_q_i`.

## Test plan
- **Reset values:** assert `arst_ni`=0 mid-RUN (period 5, counter 3) -> all flags 0, `busy_o`=0 immediately; counter held at 0 after release with no start.
- **One-shot:** start, mode 0, period 3 -> counter 3,2,1,0; `tick_o` pulses exactly once, 4 cycles after the load; `irq_o`=1; `busy_o`=0; counter stays 0 for 10 further cycles.
- **Periodic:** mode 1, period 2 -> ticks every 3 cycles. Leave `irq_clr_i` low -> `overrun_o`=1 at the second tick. Pulse `irq_clr_i` -> both clear.
- **Periodic, P=0:** mode 1, period 0 -> `tick_o` high every cycle while in RUN.
- **Stop/restart:** period 10; `stop_i` when counter=6 -> counter frozen at 6, `busy_o`=0. `start_i` with period 4 -> counter=4 next cycle.
- **Simultaneous events:**
  - Expiry + `irq_clr_i` -> `irq_o` stays 1, `overrun_o` stays 0.
  - Expiry + `stop_i` in periodic -> tick reported, IDLE, counter held at 0.
  - `start_i` + `stop_i` in IDLE -> remains IDLE.

Source files
------------

// File: rtl/reload_timer_ctrl.sv
// rtl/reload_timer_ctrl.sv - start/stop timer control around an external loadable down-counter
module reload_timer_ctrl #(
    parameter int WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_ni,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  mode_i,
    input  logic [WORD_WIDTH-1:0] period_i,
    input  logic                  irq_clr_i,
    output logic                  cnt_action_o,
    output logic [WORD_WIDTH-1:0] cnt_d_o,
    input  logic [WORD_WIDTH-1:0] cnt_q_i,
    input  logic                  cnt_zero_i,
    output logic                  busy_o,
    output logic                  tick_o,
    output logic                  irq_o,
    output logic                  overrun_o
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q;
    logic [WORD_WIDTH-1:0] period_q;
    logic                  mode_q;
    logic                  tick_q;
    logic                  irq_q;
    logic                  overrun_q;
    logic                  expiry;

    assign expiry = (state_q == RUN) && cnt_zero_i;

    // The counter decrements whenever it is not loading, so "hold" means reloading its own value.
    always_comb begin
        cnt_action_o = 1'b1;
        cnt_d_o      = cnt_q_i;
        if (!arst_ni || stop_i) begin
            cnt_action_o = 1'b1;
            cnt_d_o      = cnt_q_i;
        end else if (start_i) begin
            cnt_d_o = period_i;
        end else if (state_q == RUN) begin
            if (!cnt_zero_i) begin
                cnt_action_o = 1'b0;
            end else if (mode_q) begin
                cnt_d_o = period_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= IDLE;
            period_q  <= '0;
            mode_q    <= 1'b0;
            tick_q    <= 1'b0;
            irq_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tick_q <= expiry;

            // A new expiry wins over a clear arriving in the same cycle.
            if (expiry) begin
                irq_q <= 1'b1;
            end else if (irq_clr_i) begin
                irq_q <= 1'b0;
            end

            if (expiry && irq_q && !irq_clr_i) begin
                overrun_q <= 1'b1;
            end else if (irq_clr_i) begin
                overrun_q <= 1'b0;
            end

            if (stop_i) begin
                state_q <= IDLE;
            end else if (start_i) begin
                state_q  <= RUN;
                period_q <= period_i;
                mode_q   <= mode_i;
            end else if (expiry && !mode_q) begin
                state_q <= IDLE;
            end
        end
    end

    assign busy_o    = (state_q == RUN);
    assign tick_o    = tick_q;
    assign irq_o     = irq_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_reload_timer_ctrl.sv
// tb/tb_reload_timer_ctrl.sv - self-checking bench for reload_timer_ctrl with a down-counter model
module tb_reload_timer_ctrl;

    logic       clk = 1'b0;
    logic       arst_ni = 1'b0;
    logic       start, stop, mode, irq_clr;
    logic [7:0] period;
    logic       cnt_action;
    logic [7:0] cnt_d;
    logic [7:0] cnt_q;
    logic       cnt_zero;
    logic       busy, tick, irq, overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reload_timer_ctrl #(.WORD_WIDTH(8)) dut (
        .clk_i        (clk),
        .arst_ni      (arst_ni),
        .start_i      (start),
        .stop_i       (stop),
        .mode_i       (mode),
        .period_i     (period),
        .irq_clr_i    (irq_clr),
        .cnt_action_o (cnt_action),
        .cnt_d_o      (cnt_d),
        .cnt_q_i      (cnt_q),
        .cnt_zero_i   (cnt_zero),
        .busy_o       (busy),
        .tick_o       (tick),
        .irq_o        (irq),
        .overrun_o    (overrun)
    );

    // Attached down-counter with load and active-high asynchronous reset.
    always_ff @(posedge clk or negedge arst_ni) begin
        if (!arst_ni)        cnt_q <= 8'd0;
        else if (cnt_action) cnt_q <= cnt_d;
        else                 cnt_q <= cnt_q - 8'd1;
    end
    assign cnt_zero = (cnt_q == 8'd0);

    typedef struct {
        logic       st, sp, md;
        logic [7:0] per;
        logic       clr;
        int         rep;
        logic [7:0] q;
        logic       b, t, i, o;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       b, t, i, o;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic st, sp, md, input logic [7:0] per, input logic clr,
                        input logic [7:0] q, input logic b, t, i, o);
        exp_t e;
        @(negedge clk);
        start = st; stop = sp; mode = md; period = per; irq_clr = clr;
        e.q = q; e.b = b; e.t = t; e.i = i; e.o = o;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        cmp("cnt_q", cnt_q, e.q);
        cmp("busy", {7'd0, busy}, {7'd0, e.b});
        cmp("tick", {7'd0, tick}, {7'd0, e.t});
        cmp("irq", {7'd0, irq}, {7'd0, e.i});
        cmp("overrun", {7'd0, overrun}, {7'd0, e.o});
    endtask

    function automatic vec_t v(logic st, sp, md, logic [7:0] per, logic clr, int rep,
                               logic [7:0] q, logic b, t, i, o);
        vec_t r;
        r.st = st; r.sp = sp; r.md = md; r.per = per; r.clr = clr; r.rep = rep;
        r.q = q; r.b = b; r.t = t; r.i = i; r.o = o;
        return r;
    endfunction

    initial begin
        start = 0; stop = 0; mode = 0; period = 0; irq_clr = 0;
        #1;
        cmp("rst_busy", {7'd0, busy}, 8'd0);
        cmp("rst_tick", {7'd0, tick}, 8'd0);
        cmp("rst_irq", {7'd0, irq}, 8'd0);
        cmp("rst_ovr", {7'd0, overrun}, 8'd0);
        cmp("rst_action", {7'd0, cnt_action}, 8'd1);
        cmp("rst_d", cnt_d, cnt_q);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_ni = 1'b1;

        // Reset in the middle of a run: period 5, counter reaches 3, then abort.
        step(1, 0, 0, 8'd5, 0, 8'd5, 1, 0, 0, 0);
        step(0, 0, 0, 8'd0, 0, 8'd4, 1, 0, 0, 0);
        step(0, 0, 0, 8'd0, 0, 8'd3, 1, 0, 0, 0);
        arst_ni = 1'b0;
        #1;
        cmp("arst_busy", {7'd0, busy}, 8'd0);
        cmp("arst_tick", {7'd0, tick}, 8'd0);
        cmp("arst_irq", {7'd0, irq}, 8'd0);
        cmp("arst_cnt", cnt_q, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_ni = 1'b1;
        for (int k = 0; k < 3; k++) step(0, 0, 0, 8'd0, 0, 8'd0, 0, 0, 0, 0);

        //                st sp md per  clr rep  q    b  t  i  o
        // one-shot, period 3
        vecs.push_back(v(1, 0, 0, 8'd3, 0, 1, 8'd3, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 10, 8'd0, 0, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 1, 1, 8'd0, 0, 0, 0, 0));
        // periodic, period 2: overrun on second tick, then clear
        vecs.push_back(v(1, 0, 1, 8'd2, 0, 1, 8'd2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd2, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd1, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd2, 1, 1, 1, 1));
        vecs.push_back(v(0, 0, 0, 8'd0, 1, 1, 8'd1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd2, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd1, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 1, 0));
        // expiry coincident with irq_clr: irq kept, no overrun
        vecs.push_back(v(0, 0, 0, 8'd0, 1, 1, 8'd2, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd1, 1, 0, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 1, 0));
        // expiry coincident with stop: still reported, counter held at 0
        vecs.push_back(v(0, 1, 0, 8'd0, 0, 1, 8'd0, 0, 1, 1, 1));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 0, 0, 1, 1));
        vecs.push_back(v(0, 0, 0, 8'd0, 1, 1, 8'd0, 0, 0, 0, 0));
        // periodic, period 0: tick every RUN cycle
        vecs.push_back(v(1, 0, 1, 8'd0, 0, 1, 8'd0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 1, 1, 1));
        vecs.push_back(v(0, 0, 0, 8'd0, 1, 1, 8'd0, 1, 1, 1, 0));
        vecs.push_back(v(0, 1, 0, 8'd0, 0, 1, 8'd0, 0, 1, 1, 1));
        vecs.push_back(v(0, 0, 0, 8'd0, 1, 1, 8'd0, 0, 0, 0, 0));
        // stop at 6 freezes, restart with 4
        vecs.push_back(v(1, 0, 0, 8'd10, 0, 1, 8'd10, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd9, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd8, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd7, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd6, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 8'd0, 0, 1, 8'd6, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 3, 8'd6, 0, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 8'd4, 0, 1, 8'd4, 1, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 8'd0, 0, 1, 8'd4, 0, 0, 0, 0));
        // start together with stop in IDLE stays IDLE
        vecs.push_back(v(1, 1, 1, 8'd9, 0, 1, 8'd4, 0, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 2, 8'd4, 0, 0, 0, 0));
        // restart while running, switching to one-shot period 2
        vecs.push_back(v(1, 0, 1, 8'd7, 0, 1, 8'd7, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd6, 1, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 8'd2, 0, 1, 8'd2, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd1, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 1, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 1, 8'd0, 0, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'd0, 0, 2, 8'd0, 0, 0, 1, 0));

        for (int n = 0; n < vecs.size(); n++) begin
            for (int r = 0; r < vecs[n].rep; r++) begin
                step(vecs[n].st, vecs[n].sp, vecs[n].md, vecs[n].per, vecs[n].clr,
                     vecs[n].q, vecs[n].b, vecs[n].t, vecs[n].i, vecs[n].o);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
